// File: rtl/lsu_mem_master_if.sv
// Bundle of the core-side request/response signals and the data_mem port of the load/store unit.
// The master modport is the unit's own view; the slave modport is the core plus memory side.
interface lsu_mem_master_if #(
   parameter int ADDR_WIDTH = 12
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_write;
   logic [1:0]            req_size;
   logic                  req_unsigned;
   logic [31:0]           req_addr;
   logic [31:0]           req_wdata;
   logic                  rsp_valid;
   logic [31:0]           rsp_rdata;
   logic                  rsp_misaligned;
   logic                  mem_write;
   logic [3:0]            byte_en;
   logic [ADDR_WIDTH-1:0] addr;
   logic [31:0]           write_data;
   logic [31:0]           read_data;

   modport master (
      input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, read_data,
      output req_ready, rsp_valid, rsp_rdata, rsp_misaligned,
             mem_write, byte_en, addr, write_data
   );

   modport slave (
      output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, read_data,
      input  req_ready, rsp_valid, rsp_rdata, rsp_misaligned,
             mem_write, byte_en, addr, write_data
   );
endinterface

// File: rtl/lsu_mem_master.sv
// Load/store initiator between the CPU memory stage and data_mem: one request at a time,
// lane steering for stores, sign/zero extension for loads, misaligned accesses rejected.
module lsu_mem_master #(
   parameter int ADDR_WIDTH = 12
) (
   input  logic                clk,
   input  logic                rst,
   lsu_mem_master_if.master    bus
);

   typedef enum logic [2:0] {IDLE, ISSUE, DATA, RESP, ERR} state_t;

   state_t                state_q, state_d;
   logic                  write_q, write_d;
   logic [1:0]            size_q, size_d;
   logic                  uns_q, uns_d;
   logic [1:0]            off_q, off_d;
   logic                  req_ready_q, req_ready_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic                  rsp_mis_q, rsp_mis_d;
   logic [31:0]           rsp_rdata_q, rsp_rdata_d;
   logic                  mem_write_q, mem_write_d;
   logic [3:0]            byte_en_q, byte_en_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           write_data_q, write_data_d;

   logic [1:0]  req_off;
   logic        req_mis;
   logic [3:0]  req_be;
   logic [31:0] req_wd;
   logic [7:0]  lane_byte;
   logic [15:0] lane_half;
   logic [31:0] load_val;

   assign req_off = bus.req_addr[1:0];

   // Decode of the live request, only consumed at the accept edge.
   always_comb begin
      req_mis = 1'b0;
      req_be  = 4'b1111;
      req_wd  = bus.req_wdata;
      case (bus.req_size)
         2'b00: begin
            req_be = 4'b0001 << req_off;
            req_wd = {4{bus.req_wdata[7:0]}};
         end
         2'b01: begin
            req_mis = req_off[0];
            req_be  = 4'b0011 << req_off;
            req_wd  = {2{bus.req_wdata[15:0]}};
         end
         2'b10: req_mis = (req_off != 2'b00);
         default: req_mis = 1'b1;
      endcase
   end

   // read_data arrives one cycle after the address, i.e. while in DATA.
   always_comb begin
      lane_byte = bus.read_data[{off_q, 3'b000} +: 8];
      lane_half = off_q[1] ? bus.read_data[31:16] : bus.read_data[15:0];
      case (size_q)
         2'b00:   load_val = {{24{lane_byte[7] & ~uns_q}}, lane_byte};
         2'b01:   load_val = {{16{lane_half[15] & ~uns_q}}, lane_half};
         default: load_val = bus.read_data;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      write_d      = write_q;
      size_d       = size_q;
      uns_d        = uns_q;
      off_d        = off_q;
      addr_d       = addr_q;
      write_data_d = write_data_q;
      req_ready_d  = 1'b0;
      rsp_valid_d  = 1'b0;
      rsp_mis_d    = 1'b0;
      rsp_rdata_d  = 32'd0;
      mem_write_d  = 1'b0;
      byte_en_d    = 4'b0000;
      case (state_q)
         IDLE: begin
            req_ready_d = 1'b1;
            if (bus.req_valid) begin
               req_ready_d = 1'b0;
               write_d     = bus.req_write;
               size_d      = bus.req_size;
               uns_d       = bus.req_unsigned;
               off_d       = req_off;
               if (req_mis) begin
                  state_d     = ERR;
                  rsp_valid_d = 1'b1;
                  rsp_mis_d   = 1'b1;
               end else begin
                  state_d      = ISSUE;
                  mem_write_d  = bus.req_write;
                  byte_en_d    = req_be;
                  addr_d       = {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
                  write_data_d = req_wd;
               end
            end
         end
         ISSUE: begin
            if (write_q) begin
               state_d     = RESP;
               rsp_valid_d = 1'b1;
            end else begin
               state_d = DATA;
            end
         end
         DATA: begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = load_val;
         end
         default: begin
            state_d     = IDLE;
            req_ready_d = 1'b1;
         end
      endcase
   end

   // Every output is a flop so reset drops the memory strobe asynchronously.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         write_q      <= 1'b0;
         size_q       <= 2'b00;
         uns_q        <= 1'b0;
         off_q        <= 2'b00;
         req_ready_q  <= 1'b1;
         rsp_valid_q  <= 1'b0;
         rsp_mis_q    <= 1'b0;
         rsp_rdata_q  <= 32'd0;
         mem_write_q  <= 1'b0;
         byte_en_q    <= 4'b0000;
         addr_q       <= '0;
         write_data_q <= 32'd0;
      end else begin
         state_q      <= state_d;
         write_q      <= write_d;
         size_q       <= size_d;
         uns_q        <= uns_d;
         off_q        <= off_d;
         req_ready_q  <= req_ready_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_mis_q    <= rsp_mis_d;
         rsp_rdata_q  <= rsp_rdata_d;
         mem_write_q  <= mem_write_d;
         byte_en_q    <= byte_en_d;
         addr_q       <= addr_d;
         write_data_q <= write_data_d;
      end
   end

   assign bus.req_ready      = req_ready_q;
   assign bus.rsp_valid      = rsp_valid_q;
   assign bus.rsp_misaligned = rsp_mis_q;
   assign bus.rsp_rdata      = rsp_rdata_q;
   assign bus.mem_write      = mem_write_q;
   assign bus.byte_en        = byte_en_q;
   assign bus.addr           = addr_q;
   assign bus.write_data     = write_data_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: behavioural data_mem plus a byte-array reference model,
// directed scenarios followed by randomized traffic.
module tb_lsu_mem_master;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks_total  = 0;
   int   checks_passed = 0;

   logic [31:0] mem_words [0:1023];
   logic [7:0]  ref_mem   [0:4095];

   lsu_mem_master_if #(.ADDR_WIDTH(12)) bus_if ();

   lsu_mem_master #(.ADDR_WIDTH(12)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   always #5 clk = ~clk;

   // data_mem: byte-enabled write, one-cycle registered read of the presented address.
   always @(posedge clk) begin
      for (int b = 0; b < 4; b++)
         if (bus_if.mem_write && bus_if.byte_en[b])
            mem_words[bus_if.addr[11:2]][8*b +: 8] <= bus_if.write_data[8*b +: 8];
      bus_if.read_data <= mem_words[bus_if.addr[11:2]];
   end

   function automatic int nbytes(input logic [1:0] sz);
      return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
   endfunction

   function automatic logic model_mis(input logic [1:0] sz, input logic [31:0] a);
      return (sz == 2'b11) || ((int'(a[11:0]) % nbytes(sz)) != 0);
   endfunction

   function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns, input logic [31:0] a);
      int n = nbytes(sz);
      int base = int'(a[11:0]);
      logic [31:0] v = 32'd0;
      for (int k = 0; k < n; k++) v = v | (32'(ref_mem[base + k]) << (8 * k));
      if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
      return v;
   endfunction

   function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] a);
      logic [3:0] be = 4'b0000;
      for (int k = 0; k < nbytes(sz); k++) be[(int'(a[11:0]) % 4) + k] = 1'b1;
      return be;
   endfunction

   function automatic logic [31:0] model_wd(input logic [1:0] sz, input logic [31:0] wd);
      logic [31:0] v = 32'd0;
      for (int i = 0; i < 4; i++) v[8*i +: 8] = wd[8*(i % nbytes(sz)) +: 8];
      return v;
   endfunction

   task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
      for (int k = 0; k < nbytes(sz); k++) ref_mem[int'(a[11:0]) + k] = wd[8*k +: 8];
   endtask

   // Drives one request and records what the DUT shows on its ports until the response.
   task automatic run_req(input logic w, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic ready_at_req, output int lat, output int strobes,
                          output logic [31:0] rdata, output logic mis, output logic [3:0] be,
                          output logic we, output logic [11:0] ad, output logic [31:0] wdo);
      lat = 0; strobes = 0; rdata = 32'd0; mis = 1'b0; be = 4'd0; we = 1'b0; ad = 12'd0; wdo = 32'd0;
      @(negedge clk);
      ready_at_req = bus_if.req_ready;
      bus_if.req_valid    = 1'b1;
      bus_if.req_write    = w;
      bus_if.req_size     = sz;
      bus_if.req_unsigned = uns;
      bus_if.req_addr     = a;
      bus_if.req_wdata    = wd;
      @(posedge clk);
      @(negedge clk);
      bus_if.req_valid    = 1'b0;
      bus_if.req_write    = 1'($urandom);
      bus_if.req_size     = 2'($urandom);
      bus_if.req_unsigned = 1'($urandom);
      bus_if.req_addr     = $urandom;
      bus_if.req_wdata    = $urandom;
      for (int k = 1; k <= 10; k++) begin
         if (bus_if.mem_write || bus_if.byte_en != 4'd0) begin
            strobes++;
            be  = bus_if.byte_en;
            we  = bus_if.mem_write;
            ad  = bus_if.addr;
            wdo = bus_if.write_data;
         end
         if (bus_if.rsp_valid) begin
            lat   = k;
            rdata = bus_if.rsp_rdata;
            mis   = bus_if.rsp_misaligned;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      bus_if.req_valid = 1'b1; bus_if.req_write = 1'b1; bus_if.req_size = 2'b10;
      bus_if.req_unsigned = 1'b0; bus_if.req_addr = 32'h10; bus_if.req_wdata = 32'hFFFF_FFFF;
      repeat (3) @(negedge clk);
      checks_total++;
      if ({bus_if.req_ready, bus_if.rsp_valid, bus_if.rsp_misaligned, bus_if.mem_write} !== 4'b1000)
         $display("[TB] FAIL reset_ctrl: got ready/valid/mis/we=%b want 1000",
                  {bus_if.req_ready, bus_if.rsp_valid, bus_if.rsp_misaligned, bus_if.mem_write});
      else checks_passed++;
      checks_total++;
      if (bus_if.byte_en !== 4'd0 || bus_if.addr !== 12'd0 || bus_if.write_data !== 32'd0 || bus_if.rsp_rdata !== 32'd0)
         $display("[TB] FAIL reset_data: got be=%h addr=%h wd=%h rdata=%h want all 0",
                  bus_if.byte_en, bus_if.addr, bus_if.write_data, bus_if.rsp_rdata);
      else checks_passed++;
      bus_if.req_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      checks_total++;
      if (bus_if.req_ready !== 1'b1 || bus_if.mem_write !== 1'b0 || bus_if.rsp_valid !== 1'b0)
         $display("[TB] FAIL reset_no_capture: got ready=%b we=%b valid=%b want 1 0 0",
                  bus_if.req_ready, bus_if.mem_write, bus_if.rsp_valid);
      else checks_passed++;
   endtask

   task automatic test_directed();
      logic rdy; int lat, stb; logic [31:0] rd, wdo; logic mis, we; logic [3:0] be; logic [11:0] ad;

      run_req(1'b1, 2'b10, 1'b0, 32'h010, 32'hDEADBEEF, rdy, lat, stb, rd, mis, be, we, ad, wdo);
      model_store(2'b10, 32'h010, 32'hDEADBEEF);
      checks_total++;
      if (rdy !== 1'b1 || lat != 2 || stb != 1 || ad !== 12'h010 || be !== 4'b1111 || we !== 1'b1 || wdo !== 32'hDEADBEEF)
         $display("[TB] FAIL store_word: got rdy=%b lat=%0d stb=%0d addr=%h be=%b we=%b wd=%h want 1 2 1 010 1111 1 deadbeef",
                  rdy, lat, stb, ad, be, we, wdo);
      else checks_passed++;

      run_req(1'b0, 2'b10, 1'b0, 32'h010, 32'd0, rdy, lat, stb, rd, mis, be, we, ad, wdo);
      checks_total++;
      if (lat != 3 || rd !== 32'hDEADBEEF || mis !== 1'b0 || we !== 1'b0 || be !== 4'b1111)
         $display("[TB] FAIL load_word: got lat=%0d rdata=%h mis=%b we=%b be=%b want 3 deadbeef 0 0 1111",
                  lat, rd, mis, we, be);
      else checks_passed++;

      run_req(1'b1, 2'b00, 1'b0, 32'h013, 32'h123456A5, rdy, lat, stb, rd, mis, be, we, ad, wdo);
      model_store(2'b00, 32'h013, 32'h123456A5);
      checks_total++;
      if (be !== 4'b1000 || wdo !== 32'hA5A5A5A5 || ad !== 12'h010 || lat != 2)
         $display("[TB] FAIL store_byte: got be=%b wd=%h addr=%h lat=%0d want 1000 a5a5a5a5 010 2", be, wdo, ad, lat);
      else checks_passed++;

      run_req(1'b0, 2'b00, 1'b0, 32'h013, 32'd0, rdy, lat, stb, rd, mis, be, we, ad, wdo);
      checks_total++;
      if (rd !== 32'hFFFFFFA5) $display("[TB] FAIL load_byte_signed: got %h want ffffffa5", rd);
      else checks_passed++;
      run_req(1'b0, 2'b00, 1'b1, 32'h013, 32'd0, rdy, lat, stb, rd, mis, be, we, ad, wdo);
      checks_total++;
      if (rd !== 32'h000000A5) $display("[TB] FAIL load_byte_unsigned: got %h want 000000a5", rd);
      else checks_passed++;
      run_req(1'b0, 2'b10, 1'b0, 32'h010, 32'd0, rdy, lat, stb, rd, mis, be, we, ad, wdo);
      checks_total++;
      if (rd !== 32'hA5ADBEEF) $display("[TB] FAIL byte_neighbours: got %h want a5adbeef", rd);
      else checks_passed++;

      run_req(1'b1, 2'b01, 1'b0, 32'h022, 32'h00008001, rdy, lat, stb, rd, mis, be, we, ad, wdo);
      model_store(2'b01, 32'h022, 32'h00008001);
      checks_total++;
      if (be !== 4'b1100 || wdo !== 32'h80018001 || ad !== 12'h020)
         $display("[TB] FAIL store_half: got be=%b wd=%h addr=%h want 1100 80018001 020", be, wdo, ad);
      else checks_passed++;
      run_req(1'b0, 2'b01, 1'b0, 32'h022, 32'd0, rdy, lat, stb, rd, mis, be, we, ad, wdo);
      checks_total++;
      if (rd !== 32'hFFFF8001) $display("[TB] FAIL load_half_signed: got %h want ffff8001", rd);
      else checks_passed++;
      run_req(1'b0, 2'b01, 1'b1, 32'h022, 32'd0, rdy, lat, stb, rd, mis, be, we, ad, wdo);
      checks_total++;
      if (rd !== 32'h00008001) $display("[TB] FAIL load_half_unsigned: got %h want 00008001", rd);
      else checks_passed++;
   endtask

   task automatic test_misaligned();
      logic rdy; int lat, stb; logic [31:0] rd, wdo; logic mis, we; logic [3:0] be; logic [11:0] ad;
      logic [1:0]  sz_tab [3] = '{2'b10, 2'b01, 2'b11};
      logic        w_tab  [3] = '{1'b0, 1'b1, 1'b0};
      logic [31:0] a_tab  [3] = '{32'h006, 32'h011, 32'h018};
      for (int i = 0; i < 3; i++) begin
         run_req(w_tab[i], sz_tab[i], 1'b0, a_tab[i], 32'hFFFFFFFF, rdy, lat, stb, rd, mis, be, we, ad, wdo);
         checks_total++;
         if (lat != 1 || mis !== 1'b1 || rd !== 32'd0 || stb != 0)
            $display("[TB] FAIL misaligned_%0d: got lat=%0d mis=%b rdata=%h strobes=%0d want 1 1 0 0",
                     i, lat, mis, rd, stb);
         else checks_passed++;
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] e1 = model_load(2'b10, 1'b1, 32'h010);
      logic [31:0] e2 = model_load(2'b01, 1'b1, 32'h022);
      int rsp_n = 0, ready_bad = 0;
      int rsp_k [2] = '{0, 0};
      logic [31:0] rsp_d [2] = '{32'd0, 32'd0};
      logic ready4 = 1'b0;
      @(negedge clk);
      bus_if.req_valid = 1'b1; bus_if.req_write = 1'b0; bus_if.req_size = 2'b10;
      bus_if.req_unsigned = 1'b1; bus_if.req_addr = 32'h010;
      @(posedge clk);
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         if (k == 1) begin bus_if.req_size = 2'b01; bus_if.req_addr = 32'h022; end
         if (k == 5) bus_if.req_valid = 1'b0;
         if ((k inside {1, 2, 3, 5, 6, 7}) && bus_if.req_ready) ready_bad++;
         if (k == 4) ready4 = bus_if.req_ready;
         if (bus_if.rsp_valid && rsp_n < 2) begin
            rsp_k[rsp_n] = k; rsp_d[rsp_n] = bus_if.rsp_rdata; rsp_n++;
         end
      end
      checks_total++;
      if (ready_bad != 0 || ready4 !== 1'b1)
         $display("[TB] FAIL b2b_ready: got busy_ready_cycles=%0d ready_after_rsp=%b want 0 1", ready_bad, ready4);
      else checks_passed++;
      checks_total++;
      if (rsp_n != 2 || rsp_k[0] != 3 || rsp_k[1] != 7 || rsp_d[0] !== e1 || rsp_d[1] !== e2)
         $display("[TB] FAIL b2b_rsp: got n=%0d at %0d/%0d data %h/%h want 2 at 3/7 data %h/%h",
                  rsp_n, rsp_k[0], rsp_k[1], rsp_d[0], rsp_d[1], e1, e2);
      else checks_passed++;
   endtask

   task automatic test_reset_abort();
      logic rdy; int lat, stb; logic [31:0] rd, wdo; logic mis, we; logic [3:0] be; logic [11:0] ad;
      int rsp_seen = 0;
      logic we_issue;
      @(negedge clk);
      bus_if.req_valid = 1'b1; bus_if.req_write = 1'b1; bus_if.req_size = 2'b10;
      bus_if.req_addr = 32'h040; bus_if.req_wdata = 32'h12345678;
      @(posedge clk);
      @(negedge clk);
      bus_if.req_valid = 1'b0;
      we_issue = bus_if.mem_write;
      #1 rst = 1'b0;
      #1;
      checks_total++;
      if (we_issue !== 1'b1 || bus_if.mem_write !== 1'b0 || bus_if.byte_en !== 4'd0 || bus_if.req_ready !== 1'b1)
         $display("[TB] FAIL abort_async: got we_before=%b we=%b be=%b ready=%b want 1 0 0000 1",
                  we_issue, bus_if.mem_write, bus_if.byte_en, bus_if.req_ready);
      else checks_passed++;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (bus_if.rsp_valid) rsp_seen++;
         if (k == 2) rst = 1'b1;
      end
      checks_total++;
      if (rsp_seen != 0) $display("[TB] FAIL abort_no_rsp: got %0d responses want 0", rsp_seen);
      else checks_passed++;
      run_req(1'b0, 2'b10, 1'b0, 32'h040, 32'd0, rdy, lat, stb, rd, mis, be, we, ad, wdo);
      checks_total++;
      if (lat != 3 || rd !== 32'd0)
         $display("[TB] FAIL abort_mem_untouched: got lat=%0d rdata=%h want 3 00000000", lat, rd);
      else checks_passed++;
   endtask

   task automatic test_random();
      logic rdy; int lat, stb; logic [31:0] rd, wdo; logic mis, we; logic [3:0] be; logic [11:0] ad;
      logic w, uns; logic [1:0] sz; logic [31:0] a, wd;
      logic e_mis; int e_lat; logic [31:0] e_rd;
      for (int i = 0; i < 60; i++) begin
         w   = 1'($urandom);
         sz  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         uns = 1'($urandom);
         a   = $urandom & 32'hFFFF_F03F;
         wd  = $urandom;
         e_mis = model_mis(sz, a);
         e_lat = e_mis ? 1 : (w ? 2 : 3);
         e_rd  = (e_mis || w) ? 32'd0 : model_load(sz, uns, a);
         run_req(w, sz, uns, a, wd, rdy, lat, stb, rd, mis, be, we, ad, wdo);
         checks_total++;
         if (rdy !== 1'b1 || lat != e_lat || mis !== e_mis || rd !== e_rd)
            $display("[TB] FAIL rand_rsp_%0d: w=%b sz=%b a=%h got rdy=%b lat=%0d mis=%b rdata=%h want 1 %0d %b %h",
                     i, w, sz, a, rdy, lat, mis, rd, e_lat, e_mis, e_rd);
         else checks_passed++;
         checks_total++;
         if (e_mis) begin
            if (stb != 0) $display("[TB] FAIL rand_strobe_%0d: got %0d strobe cycles want 0", i, stb);
            else checks_passed++;
         end else begin
            if (stb != 1 || we !== w || be !== model_be(sz, a) || ad !== (a[11:0] & 12'hFFC) ||
                (w && wdo !== model_wd(sz, wd)))
               $display("[TB] FAIL rand_issue_%0d: got stb=%0d we=%b be=%b addr=%h wd=%h want 1 %b %b %h %h",
                        i, stb, we, be, ad, wdo, w, model_be(sz, a), a[11:0] & 12'hFFC, model_wd(sz, wd));
            else checks_passed++;
         end
         if (w && !e_mis) model_store(sz, a, wd);
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem_words[i] = 32'd0;
      for (int i = 0; i < 4096; i++) ref_mem[i] = 8'd0;
      bus_if.req_valid = 1'b0; bus_if.req_write = 1'b0; bus_if.req_size = 2'b00;
      bus_if.req_unsigned = 1'b0; bus_if.req_addr = 32'd0; bus_if.req_wdata = 32'd0;
      test_reset();
      test_directed();
      test_misaligned();
      test_back_to_back();
      test_reset_abort();
      test_random();
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule

// File: doc/lsu_mem_master.md
# lsu_mem_master

Load/store initiator that sits between the CPU memory stage and the word-organised data memory (`data_mem`). It accepts one load or store request at a time from the core and drives the memory's `mem_write`/`byte_en`/`addr`/`write_data` port. For stores it steers data onto the correct byte lanes. For loads it waits out the memory's one-cycle registered read, then extracts and sign- or zero-extends the selected lane. Misaligned accesses are rejected without touching memory.

## Interface
- `ADDR_WIDTH`, 12: width of the memory-side byte address; request address bits above it are ignored.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: core presents a request.
- `req_ready` out 1: block can accept; high only in IDLE.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 halfword, 10 word, 11 illegal.
- `req_unsigned` in 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out 32: load result; 0 for stores and errors.
- `rsp_misaligned` out 1: qualifies `rsp_valid`; the access was rejected.
- `mem_write` out 1: memory write strobe.
- `byte_en` out 4: memory byte-lane enables.
- `addr` out ADDR_WIDTH: memory byte address, always word-aligned (bits [1:0] = 00).
- `write_data` out 32: lane-steered store data.
- `read_data` in 32: memory read word, valid the cycle after `addr` is presented.

## Operation
- States: IDLE, ISSUE, DATA, RESP, ERR.
- **IDLE:** `req_ready` = 1. On `req_valid` at the edge, capture the request.
  - Misaligned request → ERR. Misaligned means: half with `addr[0]` = 1, word with `addr[1:0]` ≠ 0, or size 11.
  - Otherwise → ISSUE.
- **ISSUE:** drive `addr` = {captured `addr[ADDR_WIDTH-1:2]`, 2'b00}.
  - `mem_write` = captured `req_write`.
  - `byte_en`: byte → 0001 << `a[1:0]`; half → 0011 << `a[1:0]`; word → 1111.
  - Next state: store → RESP; load → DATA.
- **DATA:** `read_data` is valid. Select the byte or half by `a[1:0]`, extend per `req_unsigned`, register into `rsp_rdata` → RESP.
- **RESP:** `rsp_valid` = 1, `rsp_misaligned` = 0 → IDLE.
- **ERR:** `rsp_valid` = 1, `rsp_misaligned` = 1, `rsp_rdata` = 0; no memory strobe → IDLE.
- `write_data` lane steering:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata unchanged.
- `byte_en` enables for loads are driven identically to stores; `data_mem` ignores them on reads.
- Outside ISSUE: `mem_write` = 0 and `byte_en` = 0. `addr` and `write_data` hold their last values.
- No backpressure on responses: the core must accept `rsp_valid` in the cycle it is asserted.

## Timing
- Reset values (while `rst` is low and after release): state IDLE, `req_ready` 1, `rsp_valid` 0, `rsp_misaligned` 0, `rsp_rdata` 0, `mem_write` 0, `byte_en` 0, `addr` 0, `write_data` 0.
- Requests are never captured while `rst` is low.
- Let the accept edge be T.
  - Store: ISSUE in cycle T+1, RESP in T+2; 3-cycle occupancy.
  - Load: ISSUE T+1, DATA T+2, RESP T+3; 4-cycle occupancy.
  - Misaligned: ERR in T+1; 2-cycle occupancy.
- `req_ready` is low from T+1 until the cycle after the response, when the FSM is back in IDLE. There is no accept-in-RESP overlap.
- Reset asserted mid-operation:
  - State returns to IDLE immediately and `mem_write`/`byte_en` drop asynchronously.
  - No `rsp_valid` is produced for the aborted request.
  - A store aborted before its ISSUE edge does not modify memory.
- `req_addr` bits above ADDR_WIDTH are silently dropped, so an out-of-range address wraps.
- Request inputs are sampled only at the accept edge; they may change freely afterwards.

## Test plan
- Store word 0xDEADBEEF @0x010, then load word @0x010 → ISSUE shows `addr` 0x010, `byte_en` 1111, `mem_write` 1; load `rsp_valid` at T+3 with `rsp_rdata` 0xDEADBEEF.
- Store byte 0xA5 @0x013 → `byte_en` 1000, `write_data` 0xA5A5A5A5. Signed load byte @0x013 → 0xFFFFFFA5; unsigned → 0x000000A5. Bytes 0x010–0x012 are unchanged.
- Store half 0x8001 @0x022 → `byte_en` 1100, `write_data` 0x80018001, `addr` 0x020. Signed half load → 0xFFFF8001; unsigned → 0x00008001.
- Word load @0x006 and half store @0x011 → `rsp_valid` at T+1 with `rsp_misaligned` 1 and `rsp_rdata` 0; `mem_write` and `byte_en` stay 0 throughout.
- `req_valid` held high across two queued loads → `req_ready` low during ISSUE/DATA/RESP; second accept exactly one cycle after the first `rsp_valid`; responses in order.
- `rst` pulled low during the ISSUE cycle of a store of 0x12345678 @0x040 (memory previously 0) → `mem_write` falls at once and no `rsp_valid`; after release, load @0x040 returns 0.
